// File: rtl/xfer_pkg.sv
// Shared types and defaults for the transfer responder.
package xfer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ST_END  = 2'b00,
    ST_STOP = 2'b01,
    ST_ERR  = 2'b10,
    ST_OVF  = 2'b11
  } status_t;

  typedef struct packed {
    logic    term;
    status_t code;
  } term_t;

  localparam int ACK_LATENCY_DEF = 5;
  localparam int MAX_BEATS_DEF   = 16;
  localparam int ER_MAX_DEF      = 3;

  // Termination priority: er > stop > endd > overflow.
  function automatic term_t term_sel(input logic er, input logic stop,
                                     input logic endd, input logic ovf);
    term_t t;
    t.term = er | stop | endd | ovf;
    if (er)        t.code = ST_ERR;
    else if (stop) t.code = ST_STOP;
    else if (endd) t.code = ST_END;
    else           t.code = ST_OVF;
    return t;
  endfunction

endpackage

// File: rtl/ack_delay_line.sv
// Fixed-depth valid shift register; async clear drops anything in flight.
module ack_delay_line #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign dout = vld_pipe[DEPTH-1];

endmodule

// File: rtl/xfer_responder.sv
// Target side of the start/ready/end handshake plus delayed req/ack channel.
module xfer_responder
  import xfer_pkg::*;
#(
  parameter  int ACK_LATENCY = ACK_LATENCY_DEF,
  parameter  int MAX_BEATS   = MAX_BEATS_DEF,
  parameter  int ER_MAX      = ER_MAX_DEF,
  localparam int BEAT_W      = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              endd,
  input  logic              stop,
  input  logic              er,
  input  logic              rt,
  input  logic              req,
  output logic              rdy,
  output logic              enable,
  output logic              interrupt,
  output logic              status_valid,
  output logic [1:0]        status,
  output logic [BEAT_W-1:0] beats,
  output logic              ack,
  output logic              proto_err
);

  localparam int ER_W = $clog2(ER_MAX + 2);

  state_t            state, state_nx;
  status_t           status_q, status_nx;
  logic [BEAT_W-1:0] beats_q, beats_nx, beats_inc;
  logic              enable_q;
  logic [ER_W-1:0]   er_run;
  logic              ovf;
  term_t             term;

  assign beats_inc = beats_q + BEAT_W'(enable);
  assign ovf       = enable && (beats_inc == BEAT_W'(MAX_BEATS));
  assign term      = term_sel(er, stop, endd, ovf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beats_q  <= '0;
      status_q <= ST_END;
    end else begin
      state    <= state_nx;
      beats_q  <= beats_nx;
      status_q <= status_nx;
    end
  end

  // A terminating beat is still counted; overflow lands exactly on MAX_BEATS.
  always_comb begin
    state_nx  = state;
    beats_nx  = beats_q;
    status_nx = status_q;
    case (state)
      IDLE: if (start) begin
        state_nx = ACTIVE;
        beats_nx = '0;
      end
      ACTIVE: begin
        beats_nx = beats_inc;
        if (term.term) begin
          state_nx  = DRAIN;
          status_nx = term.code;
        end
      end
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdy          = (state == ACTIVE);
    status_valid = (state == DRAIN);
    interrupt    = (state == DRAIN);
    enable       = enable_q & ~rt;
    status       = status_q;
    beats        = beats_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) enable_q <= 1'b0;
    else     enable_q <= 1'b1;
  end

  // er_run saturates one past ER_MAX so a long burst cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      er_run    <= '0;
      proto_err <= 1'b0;
    end else if (er) begin
      if (er_run == ER_W'(ER_MAX))     proto_err <= 1'b1;
      if (er_run != ER_W'(ER_MAX + 1)) er_run <= er_run + 1'b1;
    end else begin
      er_run <= '0;
    end
  end

  ack_delay_line #(.DEPTH(ACK_LATENCY)) u_ack (
    .clk  (clk),
    .rst  (rst),
    .din  (req),
    .dout (ack)
  );

endmodule

// File: tb/tb_xfer_responder.sv
// Bench for xfer_responder: per-cycle vector table plus status/ack scoreboards.
module tb_xfer_responder;

  localparam int LAT = 5;
  localparam int MAXB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 0, endd = 0, stop = 0, er = 0, rt = 0, req = 0;
  logic       rdy, enable, interrupt, status_valid, ack, proto_err;
  logic [1:0] status;
  logic [4:0] beats;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int ack_q[$];
  int st_q[$];

  typedef struct {
    logic s, e, p, r, t;
    logic rd, en, iq;
    logic pu;
    logic [1:0] st;
    int b;
  } vec_t;
  vec_t tbl[$];

  xfer_responder #(.ACK_LATENCY(LAT), .MAX_BEATS(MAXB), .ER_MAX(3)) dut (
    .clk(clk), .rst(rst), .start(start), .endd(endd), .stop(stop), .er(er),
    .rt(rt), .req(req), .rdy(rdy), .enable(enable), .interrupt(interrupt),
    .status_valid(status_valid), .status(status), .beats(beats), .ack(ack),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic vec_t v(input logic s, e, p, r, t, rd, en, iq,
                             input logic pu = 0, input logic [1:0] st = 0, input int b = 0);
    vec_t x;
    x.s = s; x.e = e; x.p = p; x.r = r; x.t = t;
    x.rd = rd; x.en = en; x.iq = iq; x.pu = pu; x.st = st; x.b = b;
    return x;
  endfunction

  // Ack scoreboard: each sampled req is due LAT cycles later.
  always @(posedge clk) begin
    if (rst) ack_q.delete();
    else if (req) ack_q.push_back(cyc + LAT);
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    int exp_ack;
    int e;
    exp_ack = 0;
    if (rst) ack_q.delete();
    else if (ack_q.size() > 0 && ack_q[0] == cyc) begin
      exp_ack = 1;
      void'(ack_q.pop_front());
    end
    chk("ack", int'(ack), exp_ack);
    chk("irq_eq_sv", int'(interrupt), int'(status_valid));
    if (status_valid) begin
      if (st_q.size() == 0) chk("unexpected_status_valid", 1, 0);
      else begin
        e = st_q.pop_front();
        chk("status", int'(status), e / 256);
        chk("beats", int'(beats), e % 256);
      end
    end
  end

  // Enters at posedge+1, drives, checks at negedge, leaves at next posedge+1.
  task automatic step(input vec_t x);
    start = x.s; endd = x.e; stop = x.p; er = x.r; rt = x.t;
    if (x.pu) st_q.push_back(int'(x.st) * 256 + x.b);
    @(negedge clk);
    chk("rdy", int'(rdy), int'(x.rd));
    chk("enable", int'(enable), int'(x.en));
    chk("interrupt", int'(interrupt), int'(x.iq));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    start = 0; endd = 0; stop = 0; er = 0; rt = 0; req = 0;
    rst = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_outs", int'({rdy, enable, interrupt, status_valid, status, ack, proto_err}), 0);
      chk("rst_beats", int'(beats), 0);
      @(posedge clk); #1;
    end
    rst = 0;
  endtask

  task automatic ovf_run(input logic end_last);
    do_reset();
    step(v(0,0,0,0,0, 0,0,0));
    step(v(1,0,0,0,0, 0,1,0));
    for (int i = 1; i <= MAXB; i++) begin
      if (i == MAXB) step(v(0,end_last,0,0,0, 1,1,0, 1, end_last ? 2'b00 : 2'b11, MAXB));
      else           step(v(0,0,0,0,0, 1,1,0));
    end
    step(v(0,0,0,0,0, 0,1,1));
    step(v(0,0,0,0,0, 0,1,0));
    chk("beats_held", int'(beats), MAXB);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // basic transfer: 4 beats, END
    tbl.push_back(v(0,0,0,0,0, 0,0,0));
    tbl.push_back(v(1,0,0,0,0, 0,1,0));
    repeat (3) tbl.push_back(v(0,0,0,0,0, 1,1,0));
    tbl.push_back(v(0,1,0,0,0, 1,1,0, 1,2'b00,4));
    tbl.push_back(v(0,0,0,0,0, 0,1,1));
    tbl.push_back(v(0,0,0,0,0, 0,1,0));
    // rt holds 3 of 5 active cycles, STOP
    tbl.push_back(v(1,0,0,0,0, 0,1,0));
    repeat (3) tbl.push_back(v(0,0,0,0,1, 1,0,0));
    tbl.push_back(v(0,0,0,0,0, 1,1,0));
    tbl.push_back(v(0,0,1,0,0, 1,1,0, 1,2'b01,2));
    tbl.push_back(v(0,0,0,0,0, 0,1,1));
    tbl.push_back(v(0,0,0,0,0, 0,1,0));
    // terminations ignored in IDLE
    tbl.push_back(v(0,1,1,1,0, 0,1,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0));
    // er+stop+endd together -> ERR; start during DRAIN ignored
    tbl.push_back(v(1,0,0,0,0, 0,1,0));
    tbl.push_back(v(0,1,1,1,0, 1,1,0, 1,2'b10,1));
    tbl.push_back(v(1,0,0,0,0, 0,1,1));
    tbl.push_back(v(0,0,0,0,0, 0,1,0));
    // one-cycle transfers back to back at minimum spacing
    tbl.push_back(v(1,0,0,0,0, 0,1,0));
    tbl.push_back(v(0,1,0,0,0, 1,1,0, 1,2'b00,1));
    tbl.push_back(v(0,0,0,0,0, 0,1,1));
    tbl.push_back(v(1,0,0,0,0, 0,1,0));
    tbl.push_back(v(0,0,1,0,1, 1,0,0, 1,2'b01,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,1));
    tbl.push_back(v(0,0,0,0,0, 0,1,0));

    @(posedge clk); #1;
    do_reset();
    foreach (tbl[i]) step(tbl[i]);

    // overflow, then END on the 16th beat
    ovf_run(1'b0);
    ovf_run(1'b1);

    // er runs: 3 legal, then 4 sets the sticky flag
    do_reset();
    step(v(0,0,0,0,0, 0,0,0));
    repeat (3) step(v(0,0,0,1,0, 0,1,0));
    step(v(0,0,0,0,0, 0,1,0));
    chk("proto_err_3", int'(proto_err), 0);
    for (int i = 1; i <= 4; i++) begin
      step(v(0,0,0,1,0, 0,1,0));
      chk("proto_err_run", int'(proto_err), (i == 4) ? 1 : 0);
    end
    repeat (3) begin
      step(v(0,0,0,0,0, 0,1,0));
      chk("proto_err_sticky", int'(proto_err), 1);
    end
    do_reset();

    // ack: pulses at 0,1,4 then a held run of 3; then same with reset at 3..4
    step(v(0,0,0,0,0, 0,0,0));
    for (int i = 0; i < 20; i++) begin
      req = (i == 0 || i == 1 || i == 4 || (i >= 8 && i <= 10));
      @(posedge clk); #1;
    end
    req = 0;
    for (int i = 0; i < 12; i++) begin
      req = (i == 0 || i == 1 || i == 4);
      rst = (i == 3 || i == 4);
      @(posedge clk); #1;
    end
    req = 0; rst = 0;
    repeat (8) begin @(posedge clk); #1; end

    chk("status_queue_empty", st_q.size(), 0);
    chk("ack_queue_empty", ack_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/xfer_responder.md
# xfer_responder

Target-side responder for the start/ready/end transfer handshake and the req/ack channel driven by the `z1` initiator. Accepts `start`, tracks an active transfer with a beat counter, and terminates it on end/stop/error/overflow with a one-cycle status report and interrupt. Acknowledges every request cycle after a fixed latency. Flags initiator error-protocol violations. Sits beside `z1` in the same `top` and is checked by that bench's property set.

## Interface
- `ACK_LATENCY`, 5, cycles from a sampled `req` to the matching `ack` (≥1)
- `MAX_BEATS`, 16, beat count that forces an overflow termination (≥2)
- `ER_MAX`, 3, longest legal run of consecutive `er` cycles
- `BEAT_W`, $clog2(MAX_BEATS+1), beat counter width (derived)
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `start` in 1: initiator requests a transfer
- `endd` in 1: normal end of transfer
- `stop` in 1: initiator abort
- `er` in 1: initiator error
- `rt` in 1: retry/hold; beats do not count while high
- `req` in 1: request cycle on the req/ack channel
- `rdy` out 1: transfer active
- `enable` out 1: beat-counting enable
- `interrupt` out 1: one-cycle termination pulse
- `status_valid` out 1: `status`/`beats` valid this cycle
- `status` out 2: 00 END, 01 STOP, 10 ERR, 11 OVF
- `beats` out BEAT_W: enabled beats in the last or current transfer
- `ack` out 1: delayed acknowledge
- `proto_err` out 1: sticky error-protocol violation

## Operation
- Reset: async to IDLE. All outputs 0, ack pipeline cleared, `enable_q`=0.
- FSM states: IDLE, ACTIVE, DRAIN. `rdy`=(state==ACTIVE). `interrupt`=`status_valid`=(state==DRAIN). All are registered state decodes.
- IDLE: `start`=1 → ACTIVE and clear `beats`. `endd`/`stop`/`er` are ignored in IDLE.
- ACTIVE: `start` is ignored. Termination priority is `er` > `stop` > `endd` > overflow. Any termination → DRAIN with the matching `status`.
- Beat counting: `beats` increments on each ACTIVE cycle with `enable`=1. If the increment would reach MAX_BEATS → DRAIN, status OVF, `beats`=MAX_BEATS. A simultaneous termination input wins and still counts the beat.
- DRAIN: lasts one cycle, then → IDLE. `start` is ignored. `beats` is held until the next ACTIVE entry.
- `enable` = `enable_q` & !`rt`, combinational in `rt`. `enable_q` sets to 1 on the first clock after reset release and stays 1.
- ack: each cycle `req`=1 is sampled, `ack`=1 exactly ACK_LATENCY cycles later. Back-to-back and held requests produce equal-length ack runs. No other gating.
- proto_err: `er_run` saturates at ER_MAX+1 and clears on `er`=0. `proto_err` sets when `er` is sampled high with `er_run`==ER_MAX. Cleared only by `rst`.

## Timing
- `start` sampled at edge k in IDLE → `rdy`=1 from cycle k+1.
- Termination sampled at edge m → cycle m+1: `rdy`=0, `interrupt`=1, `status_valid`=1. Cycle m+2: IDLE. The earliest new `start` is sampled at edge m+2, giving `rdy` at m+3.
- Minimum ACTIVE duration is 1 cycle.
- `rt` affects `enable` in the same cycle. The counter effect appears at the next edge.
- Reset asserted mid-transfer: outputs drop immediately and no status is reported. In-flight acks are discarded.

## Structure
- Package `xfer_pkg`:
  - `state_t` (IDLE, ACTIVE, DRAIN)
  - `status_t` (ST_END=2'b00, ST_STOP, ST_ERR, ST_OVF)
  - default constants for ACK_LATENCY, MAX_BEATS, ER_MAX
- Sub-module `ack_delay_line`: ACK_LATENCY-deep shift register with async clear. Instantiated once for `req`→`ack`.

## Test plan
- Reset release; `start` at cycle 2; `endd` at cycle 6, `rt`=0 → `rdy` high cycles 3–6, cycle 7 `interrupt`=`status_valid`=1, status=00, beats=4.
- `start`; hold `rt`=1 for 3 ACTIVE cycles; `stop` after 5 ACTIVE cycles → `enable`=0 during `rt`, beats=2, status=01.
- `start`, then no termination → after 16 enabled beats DRAIN with status=11, beats=16. Repeat with `endd` on the 16th beat → status=00.
- `req` pulses at cycles 10, 11, 14 → `ack` at 15, 16, 19 only. Assert `rst` at cycle 13 → no ack at 15/16/19.
- `er` high for 3 cycles → `proto_err`=0. Then `er` high for 4 consecutive cycles → `proto_err`=1 from the cycle after the 4th, stays high until `rst`.
- `er`+`stop`+`endd` in the same ACTIVE cycle → status=10. `start` during DRAIN is ignored; the state returns to IDLE.
